// File: rtl/full_adder_if.sv
// Operand/result bundle for the clocked full adder.
// Ports: i_a, i_b (WIDTH) and i_x (1) are operands/carry-in driven by the master;
//        o_s (WIDTH) and o_c (1) are the registered sum/carry-out driven by the adder.
interface full_adder_if #(
   parameter int WIDTH = 1
) ();
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_x;
   logic [WIDTH-1:0] o_s;
   logic             o_c;

   // master: stimulus side, drives operands and observes the result
   modport master (output i_a, i_b, i_x, input o_s, o_c);
   // slave: the adder itself
   modport slave  (input i_a, i_b, i_x, output o_s, o_c);
endinterface

// File: rtl/full_adder.sv
// Purpose: WIDTH-bit ripple-carry adder (chain of 1-bit full-adder cells), result registered.
// Latency: 1 cycle, one addition per cycle; no enable, the register loads every edge.
// Backpressure: none; synchronous active-low reset clears {o_c, o_s}.
// Ports: i_clk clock, i_rst_n sync reset (active low), fa = full_adder_if slave
//        (i_a, i_b, i_x in; o_s, o_c out). WIDTH legal range 1..64.
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   full_adder_if.slave fa
);

   logic [WIDTH:0]   w_c;     // carry chain, w_c[0] is the carry-in
   logic [WIDTH-1:0] w_s;     // combinational sum bits
   logic [WIDTH:0]   r_res;   // registered {carry-out, sum}

   assign w_c[0] = fa.i_x;

   // Identical 1-bit cells; the carry ripples from bit 0 upward.
   for (genvar k = 0; k < WIDTH; k++) begin : g_cell
      assign w_s[k]   = fa.i_a[k] ^ fa.i_b[k] ^ w_c[k];
      assign w_c[k+1] = (fa.i_a[k] & fa.i_b[k])
                      | (fa.i_a[k] & w_c[k])
                      | (fa.i_b[k] & w_c[k]);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_res <= '0;
      end else begin
         r_res <= {w_c[WIDTH], w_s};
      end
   end

   assign fa.o_s = r_res[WIDTH-1:0];
   assign fa.o_c = r_res[WIDTH];

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   full_adder_if #(.WIDTH(1)) if1 ();
   full_adder_if #(.WIDTH(4)) if4 ();
   full_adder_if #(.WIDTH(8)) if8 ();

   full_adder #(.WIDTH(1)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .fa(if1.slave));
   full_adder #(.WIDTH(4)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .fa(if4.slave));
   full_adder #(.WIDTH(8)) u_dut8 (.i_clk(clk), .i_rst_n(rst_n), .fa(if8.slave));

   int n_checks = 0;
   int n_errors = 0;

   // scoreboards of expected {carry, sum}, one per adder width
   logic [1:0] q1[$];
   logic [4:0] q4[$];
   logic [8:0] q8[$];

   // last result seen on each adder, used to confirm outputs hold between edges
   logic [1:0] last1;
   logic [4:0] last4;
   logic [8:0] last8;
   bit         armed = 1'b0;

   task automatic check_eq(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, confirm outputs did not move,
   // push expectations, then compare just after the rising edge.
   task automatic cycle(input logic rst, input logic [2:0] v1,
                        input logic [3:0] a4, input logic [3:0] b4, input logic x4,
                        input string tag);
      logic [7:0] a8;
      logic [7:0] b8;
      logic       x8;
      logic [1:0] e1;
      logic [4:0] e4;
      logic [8:0] e8;
      a8 = 8'($urandom_range(255));
      b8 = 8'($urandom_range(255));
      x8 = 1'($urandom_range(1));

      @(negedge clk);
      rst_n  = rst;
      if1.i_a = v1[0];
      if1.i_b = v1[1];
      if1.i_x = v1[2];
      if4.i_a = a4;
      if4.i_b = b4;
      if4.i_x = x4;
      if8.i_a = a8;
      if8.i_b = b8;
      if8.i_x = x8;
      #1;
      if (armed) begin
         check_eq({tag, "/hold1"}, 65'({if1.o_c, if1.o_s}), 65'(last1));
         check_eq({tag, "/hold4"}, 65'({if4.o_c, if4.o_s}), 65'(last4));
         check_eq({tag, "/hold8"}, 65'({if8.o_c, if8.o_s}), 65'(last8));
      end

      q1.push_back(rst ? ({1'b0, v1[0]} + {1'b0, v1[1]} + {1'b0, v1[2]}) : 2'd0);
      q4.push_back(rst ? ({1'b0, a4} + {1'b0, b4} + {4'd0, x4}) : 5'd0);
      q8.push_back(rst ? ({1'b0, a8} + {1'b0, b8} + {8'd0, x8}) : 9'd0);

      @(posedge clk);
      #1;
      e1 = q1.pop_front();
      e4 = q4.pop_front();
      e8 = q8.pop_front();
      check_eq({tag, "/w1"}, 65'({if1.o_c, if1.o_s}), 65'(e1));
      check_eq({tag, "/w4"}, 65'({if4.o_c, if4.o_s}), 65'(e4));
      check_eq({tag, "/w8"}, 65'({if8.o_c, if8.o_s}), 65'(e8));
      last1 = e1;
      last4 = e4;
      last8 = e8;
      armed = 1'b1;
   endtask

   function automatic logic [3:0] r4();
      return 4'($urandom_range(15));
   endfunction

   initial begin
      if1.i_a = 1'b1; if1.i_b = 1'b1; if1.i_x = 1'b1;
      if4.i_a = 4'hF; if4.i_b = 4'hF; if4.i_x = 1'b1;
      if8.i_a = '0;   if8.i_b = '0;   if8.i_x = 1'b0;

      // reset held for two edges with all-ones inputs, then released
      cycle(1'b0, 3'b111, 4'hF, 4'hF, 1'b1, "rst0");
      cycle(1'b0, 3'b111, 4'hF, 4'hF, 1'b1, "rst1");
      cycle(1'b1, 3'b111, 4'hF, 4'hF, 1'b1, "rst_release");

      // exhaustive single-bit truth table, {x,b,a} = 000..111
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 3'(i), r4(), r4(), 1'($urandom_range(1)), $sformatf("exh%0d", i));

      // back-to-back alternating 000 / 111
      for (int i = 0; i < 8; i++)
         cycle(1'b1, (i % 2) ? 3'b111 : 3'b000, r4(), r4(), 1'($urandom_range(1)),
               $sformatf("alt%0d", i));

      // mid-stream single-edge reset pulse with inputs held at 111
      cycle(1'b1, 3'b111, 4'hF, 4'hF, 1'b1, "mid_pre");
      cycle(1'b0, 3'b111, 4'hF, 4'hF, 1'b1, "mid_rst");
      cycle(1'b1, 3'b111, 4'hF, 4'hF, 1'b1, "mid_back");

      // 4-bit carry ripple corner cases
      cycle(1'b1, 3'b000, 4'hF, 4'h0, 1'b1, "w4_f_0_1");
      cycle(1'b1, 3'b000, 4'hF, 4'hF, 1'b1, "w4_f_f_1");
      cycle(1'b1, 3'b000, 4'h5, 4'hA, 1'b0, "w4_5_a_0");

      // random vectors on all widths
      for (int i = 0; i < 1000; i++)
         cycle(1'b1, 3'($urandom_range(7)), r4(), r4(), 1'($urandom_range(1)), "rand");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/full_adder.md
# full_adder

Clocked full adder: adds two operands and a carry-in, and registers the sum and carry-out. The default configuration is the single-bit adder cell used by the basic arithmetic exercises. The WIDTH parameter widens it to an N-bit ripple-carry adder built as a chain of identical 1-bit full-adder cells. It sits behind stimulus/register logic and feeds downstream logic or wave-dump observation.

## Interface
- WIDTH, default 1: operand and sum width in bits. Legal range is 1 to 64.
- i_clk  input  1  rising-edge clock; the only clock.
- i_rst_n  input  1  reset, synchronous and active-low, sampled on the i_clk rising edge.
- i_a  input  WIDTH  operand A, unsigned.
- i_b  input  WIDTH  operand B, unsigned.
- i_x  input  1  carry-in, weight 2^0.
- o_s  output  WIDTH  registered sum, bits [WIDTH-1:0] of i_a + i_b + i_x.
- o_c  output  1  registered carry-out, bit WIDTH of i_a + i_b + i_x.

## Operation
- Each 1-bit cell k computes:
  - s_k = a_k ^ b_k ^ c_k
  - c_(k+1) = (a_k & b_k) | (a_k & c_k) | (b_k & c_k)
- Cell 0 takes c_0 = i_x.
- Carry ripples from bit 0 to bit WIDTH-1; the final carry c_WIDTH is the carry-out.
- The adder is pure combinational logic feeding a (WIDTH+1)-bit output register {o_c, o_s}.
- The result is exact: {o_c, o_s} = i_a + i_b + i_x, computed in WIDTH+1 bits with no overflow loss.
- Arithmetic is unsigned only; there are no signed, saturation or overflow-flag semantics.
- There is no enable or handshake: the register loads every clock.
- Inputs that are X or Z propagate as unknown; no masking is required.
- Truth table for WIDTH=1 ({i_x,i_b,i_a} -> {o_c,o_s}):
  - 000->00
  - 001->01
  - 010->01
  - 011->10
  - 100->01
  - 101->10
  - 110->10
  - 111->11

## Timing
- Reset: if i_rst_n=0 at a rising edge, o_s <= 0 and o_c <= 0 at that edge, regardless of the inputs.
- Reset is not asynchronous: asserting i_rst_n between edges does not change the outputs until the next rising edge.
- Latency is exactly 1 cycle. Inputs sampled at edge n appear on o_s/o_c immediately after edge n and hold until edge n+1.
- Throughput is one addition per cycle. Inputs may change every cycle.
- Reset release: the first edge with i_rst_n=1 captures the current inputs. No dead cycle.
- Reset mid-operation: the result in flight is discarded and the outputs read 0 for every edge where i_rst_n=0.
- Before the first reset edge, the output values are undefined. The bench does not check outputs until after one reset edge.
- All paths are input -> ripple chain -> register. There are no combinational input-to-output paths.
- Critical path is the WIDTH-cell carry chain, which must close within one i_clk period.

## Test plan
- Reset: hold i_rst_n=0 for 2 edges with i_a=1, i_b=1, i_x=1 -> o_s=0 and o_c=0 after each edge. Release reset -> o_c=1, o_s=1 after the next edge.
- Exhaustive, WIDTH=1: apply all 8 {i_x,i_b,i_a} combinations in order 000 to 111, one per cycle. Each result appears one edge later and matches the truth table, e.g. 011->{1,0} and 100->{0,1}.
- Latency/back-to-back, WIDTH=1: alternate 000 and 111 every cycle -> outputs alternate {0,0} and {1,1}, delayed by exactly one edge.
- Mid-stream reset: drive 111, then pulse i_rst_n=0 for one edge while inputs stay 111 -> outputs are {0,0} for that edge only and return to {1,1} on the following edge.
- Wide carry ripple, WIDTH=4:
  - 4'hF + 4'h0 + 1 -> o_s=4'h0, o_c=1.
  - 4'hF + 4'hF + 1 -> o_s=4'hF, o_c=1.
  - 4'h5 + 4'hA + 0 -> o_s=4'hF, o_c=0.
- Random, WIDTH=8: 1000 random vectors -> {o_c, o_s} equals the 9-bit reference sum of the previous cycle's inputs.
